// File: rtl/ghash_accum.sv
// GHASH sequencer: masks and folds blocks into the accumulator via an external
// gfmul pipeline, then hashes len(A)||len(C). Optional GHASH_ORDER_CHK_EN adds oErr.
module ghash_accum #(
  parameter int MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iStart,
  input  logic [127:0] iHashkey,
  input  logic         iBlkValid,
  input  logic [127:0] iBlkData,
  input  logic         iBlkIsAad,
  input  logic [4:0]   iBlkBytes,
  output logic         oBlkReady,
  input  logic         iFinal,
  output logic [127:0] oMulA,
  output logic [127:0] oMulH,
  input  logic [127:0] iMulResult,
  output logic [127:0] oTagHash,
  output logic         oTagValid,
  output logic         oBusy
`ifdef GHASH_ORDER_CHK_EN
  ,
  output logic         oErr
`endif
);

  localparam int CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(MUL_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_MUL,
    S_LEN,
    S_LWAIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [127:0]  acc_q, acc_d;
  logic [127:0]  h_q, h_d;
  logic [63:0]   len_a_q, len_a_d;
  logic [63:0]   len_c_q, len_c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fin_q, fin_d;
  logic [127:0]  mul_a_q, mul_a_d;
  logic [127:0]  tag_q, tag_d;
  logic          tag_vld_q, tag_vld_d;
`ifdef GHASH_ORDER_CHK_EN
  logic          seen_c_q, seen_c_d;
  logic          err_q, err_d;
`endif

  logic [4:0]   nbytes;
  logic [4:0]   pad_bytes;
  logic [127:0] blk_mask;
  logic [127:0] blk_masked;
  logic [63:0]  len_inc;
  logic         blk_rdy;
  logic         xfer;

  // Byte-granular mask of the incoming block and its bit length.
  always_comb begin
    nbytes = iBlkBytes;
    if (iBlkBytes == 5'd0 || iBlkBytes > 5'd16) begin
      nbytes = 5'd16;
    end
    pad_bytes  = 5'd16 - nbytes;
    blk_mask   = {128{1'b1}} << {pad_bytes, 3'b000};
    blk_masked = iBlkData & blk_mask;
    len_inc    = {56'd0, nbytes, 3'b000};
  end

  assign blk_rdy = (state_q == S_ACCEPT) && !fin_q;
  assign xfer    = iBlkValid && blk_rdy;

  // Next-state and datapath updates; iStart overrides everything else.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    h_d       = h_q;
    len_a_d   = len_a_q;
    len_c_d   = len_c_q;
    cnt_d     = cnt_q;
    fin_d     = fin_q;
    mul_a_d   = mul_a_q;
    tag_d     = tag_q;
    tag_vld_d = 1'b0;
`ifdef GHASH_ORDER_CHK_EN
    seen_c_d  = seen_c_q;
    err_d     = err_q;
`endif
    if (iStart) begin
      state_d  = S_ACCEPT;
      acc_d    = '0;
      h_d      = iHashkey;
      len_a_d  = '0;
      len_c_d  = '0;
      cnt_d    = '0;
      fin_d    = 1'b0;
`ifdef GHASH_ORDER_CHK_EN
      seen_c_d = 1'b0;
      err_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          fin_d = 1'b0;
        end
        S_ACCEPT: begin
          fin_d = fin_q | iFinal;
          if (xfer) begin
            mul_a_d = acc_q ^ blk_masked;
            cnt_d   = LAT;
            state_d = S_MUL;
            if (iBlkIsAad) begin
              len_a_d = len_a_q + len_inc;
            end else begin
              len_c_d = len_c_q + len_inc;
            end
`ifdef GHASH_ORDER_CHK_EN
            if (iBlkIsAad && seen_c_q) begin
              err_d = 1'b1;
            end
            if (!iBlkIsAad) begin
              seen_c_d = 1'b1;
            end
`endif
          end else if (fin_q) begin
            state_d = S_LEN;
          end
        end
        S_MUL: begin
          fin_d = fin_q | iFinal;
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) begin
            acc_d   = iMulResult;
            state_d = S_ACCEPT;
          end
        end
        S_LEN: begin
          mul_a_d = acc_q ^ {len_a_q, len_c_q};
          cnt_d   = LAT;
          state_d = S_LWAIT;
        end
        S_LWAIT: begin
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) begin
            acc_d   = iMulResult;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          tag_d     = acc_q;
          tag_vld_d = 1'b1;
          fin_d     = 1'b0;
          state_d   = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      h_q       <= '0;
      len_a_q   <= '0;
      len_c_q   <= '0;
      cnt_q     <= '0;
      fin_q     <= 1'b0;
      mul_a_q   <= '0;
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
`ifdef GHASH_ORDER_CHK_EN
      seen_c_q  <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      h_q       <= h_d;
      len_a_q   <= len_a_d;
      len_c_q   <= len_c_d;
      cnt_q     <= cnt_d;
      fin_q     <= fin_d;
      mul_a_q   <= mul_a_d;
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
`ifdef GHASH_ORDER_CHK_EN
      seen_c_q  <= seen_c_d;
      err_q     <= err_d;
`endif
    end
  end

  assign oBlkReady = blk_rdy;
  assign oMulA     = mul_a_q;
  assign oMulH     = h_q;
  assign oTagHash  = tag_q;
  assign oTagValid = tag_vld_q;
  assign oBusy     = (state_q != S_IDLE);
`ifdef GHASH_ORDER_CHK_EN
  assign oErr      = err_q;
`endif

endmodule

// File: tb/tb_ghash_accum.sv
// Bench for ghash_accum: behavioural gfmul pipeline and GHASH reference model,
// randomized blocks, one task per scenario.
module tb_ghash_accum;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         iStart;
  logic [127:0] iHashkey;
  logic         iBlkValid;
  logic [127:0] iBlkData;
  logic         iBlkIsAad;
  logic [4:0]   iBlkBytes;
  logic         oBlkReady;
  logic         iFinal;
  logic [127:0] oMulA;
  logic [127:0] oMulH;
  logic [127:0] iMulResult;
  logic [127:0] oTagHash;
  logic         oTagValid;
  logic         oBusy;
`ifdef GHASH_ORDER_CHK_EN
  logic         oErr;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [127:0] q_data[$];
  logic [4:0]   q_bytes[$];
  bit           q_aad[$];
  int           gap_q[$];
  int           xc_q[$];

  ghash_accum #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .iStart(iStart), .iHashkey(iHashkey),
    .iBlkValid(iBlkValid), .iBlkData(iBlkData), .iBlkIsAad(iBlkIsAad),
    .iBlkBytes(iBlkBytes), .oBlkReady(oBlkReady), .iFinal(iFinal),
    .oMulA(oMulA), .oMulH(oMulH), .iMulResult(iMulResult),
    .oTagHash(oTagHash), .oTagValid(oTagValid), .oBusy(oBusy)
`ifdef GHASH_ORDER_CHK_EN
    , .oErr(oErr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] gf_mul(input logic [127:0] x,
                                          input logic [127:0] y);
    logic [127:0] z = '0;
    logic [127:0] v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
      else v = v >> 1;
    end
    return z;
  endfunction

  // gfmul stand-in: result visible LAT cycles after a launch, counting launch cycle.
  logic [127:0] p1 = '0, p2 = '0, p3 = '0;
  always @(posedge clk) begin
    p1 <= oMulA;
    p2 <= p1;
    p3 <= p2;
  end
  always_comb iMulResult = gf_mul(p3, oMulH);

  function automatic logic [127:0] mask_blk(input logic [127:0] d,
                                            input logic [4:0] b);
    logic [127:0] m = '0;
    int n = (b == 0 || b > 16) ? 16 : int'(b);
    for (int j = 0; j < n; j++) m[127-8*j -: 8] = d[127-8*j -: 8];
    return m;
  endfunction

  function automatic logic [127:0] ref_ghash(input logic [127:0] h);
    logic [127:0] acc = '0;
    logic [63:0] la = '0;
    logic [63:0] lc = '0;
    int n;
    foreach (q_data[i]) begin
      n = (q_bytes[i] == 0 || q_bytes[i] > 16) ? 16 : int'(q_bytes[i]);
      acc = gf_mul(acc ^ mask_blk(q_data[i], q_bytes[i]), h);
      if (q_aad[i]) la = la + 64'(8 * n);
      else lc = lc + 64'(8 * n);
    end
    return gf_mul(acc ^ {la, lc}, h);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_bytes.delete();
    q_aad.delete();
  endtask

  task automatic do_start(input logic [127:0] h);
    iStart = 1'b1;
    iHashkey = h;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic pulse_final();
    iFinal = 1'b1;
    @(negedge clk);
    iFinal = 1'b0;
  endtask

  task automatic send_blocks(input bit fin_last, output bit ok);
    int n;
    ok = 1'b1;
    gap_q.delete();
    xc_q.delete();
    foreach (q_data[i]) begin
      iBlkValid = 1'b1;
      iBlkData = q_data[i];
      iBlkBytes = q_bytes[i];
      iBlkIsAad = q_aad[i];
      n = 0;
      while (!oBlkReady && n < 64) begin
        @(negedge clk);
        n++;
      end
      if (!oBlkReady) ok = 1'b0;
      gap_q.push_back(n);
      xc_q.push_back(cyc);
      if (fin_last && i == q_data.size() - 1) iFinal = 1'b1;
      @(negedge clk);
      iFinal = 1'b0;
    end
    iBlkValid = 1'b0;
  endtask

  task automatic wait_tag(output logic [127:0] t, output bit ok);
    ok = 1'b0;
    t = '0;
    for (int i = 0; i < 100; i++) begin
      if (oTagValid) begin
        ok = 1'b1;
        t = oTagHash;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({oBlkReady, oTagValid, oBusy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 000", {oBlkReady, oTagValid, oBusy});
    end
    checks++;
    if ({oMulA, oMulH, oTagHash} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h exp 0", oMulA, oMulH, oTagHash);
    end
`ifdef GHASH_ORDER_CHK_EN
    checks++;
    if (oErr !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b exp 0", oErr);
    end
`endif
    rst = 1'b0;
    iBlkValid = 1'b1;
    iFinal = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({oBusy, oBlkReady, oTagValid} !== 3'b000) begin
      errors++;
      $display("FAIL idle_ignore got %b exp 000", {oBusy, oBlkReady, oTagValid});
    end
    iBlkValid = 1'b0;
    iFinal = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_c();
    logic [127:0] h = 128'hb83b533708bf535d0aa6e52980d53b78;
    logic [127:0] b = 128'hfeedfacedeadbeeffeedfacedeadbeef;
    logic [127:0] t, r1;
    bit ok;
    do_start(h);
    checks++;
    if (oMulH !== h) begin
      errors++;
      $display("FAIL t1_mulh got %h exp %h", oMulH, h);
    end
    clear_q();
    q_data.push_back(b); q_bytes.push_back(5'd16); q_aad.push_back(1'b0);
    send_blocks(1'b0, ok);
    checks++;
    if (!ok || oMulA !== b) begin
      errors++;
      $display("FAIL t1_mula got %h exp %h ok %0d", oMulA, b, ok);
    end
    pulse_final();
    wait_tag(t, ok);
    r1 = gf_mul(b, h);
    checks++;
    if (!ok || oMulA !== (r1 ^ 128'h80)) begin
      errors++;
      $display("FAIL t1_len got %h exp %h ok %0d", oMulA, r1 ^ 128'h80, ok);
    end
    checks++;
    if (!ok || t !== ref_ghash(h)) begin
      errors++;
      $display("FAIL t1_tag got %h exp %h ok %0d", t, ref_ghash(h), ok);
    end
    @(negedge clk);
    checks++;
    if ({oTagValid, oBusy} !== 2'b00 || oTagHash !== ref_ghash(h)) begin
      errors++;
      $display("FAIL t1_pulse got %b %h exp 00 %h", {oTagValid, oBusy}, oTagHash, ref_ghash(h));
    end
  endtask

  task automatic test_partial_aad();
    logic [127:0] h = rnd128();
    logic [127:0] mexp = 128'hffffffff000000000000000000000000;
    logic [127:0] ones = '1;
    logic [127:0] t;
    bit ok;
    do_start(h);
    clear_q();
    q_data.push_back(ones); q_bytes.push_back(5'd4); q_aad.push_back(1'b1);
    send_blocks(1'b1, ok);
    checks++;
    if (!ok || oMulA !== mexp) begin
      errors++;
      $display("FAIL t2_mask got %h exp %h ok %0d", oMulA, mexp, ok);
    end
    wait_tag(t, ok);
    checks++;
    if (!ok || oMulA !== (gf_mul(mexp, h) ^ {64'h20, 64'h0})) begin
      errors++;
      $display("FAIL t2_len got %h exp %h ok %0d", oMulA, gf_mul(mexp, h) ^ {64'h20, 64'h0}, ok);
    end
    checks++;
    if (!ok || t !== ref_ghash(h)) begin
      errors++;
      $display("FAIL t2_tag got %h exp %h ok %0d", t, ref_ghash(h), ok);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] h = rnd128();
    logic [127:0] t;
    bit ok;
    do_start(h);
    clear_q();
    for (int i = 0; i < 3; i++) begin
      q_data.push_back(rnd128()); q_bytes.push_back(5'd16); q_aad.push_back(i == 0);
    end
    send_blocks(1'b0, ok);
    checks++;
    if (!ok || xc_q.size() != 3) begin
      errors++;
      $display("FAIL t3_xfer got ok %0d n %0d exp ok 1 n 3", ok, xc_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (gap_q[i] != LAT || xc_q[i] - xc_q[i-1] != LAT + 1) begin
          errors++;
          $display("FAIL t3_gap%0d got %0d/%0d exp %0d/%0d", i, gap_q[i], xc_q[i] - xc_q[i-1], LAT, LAT + 1);
        end
      end
    end
    pulse_final();
    wait_tag(t, ok);
    checks++;
    if (!ok || t !== ref_ghash(h)) begin
      errors++;
      $display("FAIL t3_tag got %h exp %h ok %0d", t, ref_ghash(h), ok);
    end
  endtask

  task automatic test_empty();
    logic [127:0] h = 128'h1;
    logic [127:0] prev = oTagHash;
    logic [127:0] t;
    do_start(h);
    checks++;
    if (oTagHash !== prev) begin
      errors++;
      $display("FAIL t4_retain got %h exp %h", oTagHash, prev);
    end
    clear_q();
    pulse_final();
    begin
      bit ok;
      wait_tag(t, ok);
      checks++;
      if (!ok || t !== ref_ghash(h) || oMulA !== '0) begin
        errors++;
        $display("FAIL t4_tag got %h mula %h exp %h ok %0d", t, oMulA, ref_ghash(h), ok);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_start(rnd128());
    clear_q();
    q_data.push_back(rnd128()); q_bytes.push_back(5'd16); q_aad.push_back(1'b0);
    send_blocks(1'b0, ok);
    checks++;
    if (!ok || oBusy !== 1'b1 || oBlkReady !== 1'b0) begin
      errors++;
      $display("FAIL t5_inmul got busy %b rdy %b exp 1 0", oBusy, oBlkReady);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({oBusy, oBlkReady, oTagValid} !== 3'b000 || {oMulA, oMulH, oTagHash} !== '0) begin
      errors++;
      $display("FAIL t5_rst got %b %h %h %h exp 0", {oBusy, oBlkReady, oTagValid}, oMulA, oMulH, oTagHash);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [127:0] h2 = rnd128();
    logic [127:0] y = rnd128();
    logic [127:0] t;
    bit ok;
    do_start(rnd128());
    clear_q();
    for (int i = 0; i < 2; i++) begin
      q_data.push_back(rnd128()); q_bytes.push_back(5'd16); q_aad.push_back(1'b1);
    end
    send_blocks(1'b0, ok);
    @(negedge clk);
    do_start(h2);
    checks++;
    if (oMulH !== h2 || oBlkReady !== 1'b1) begin
      errors++;
      $display("FAIL t5_abort got %h rdy %b exp %h 1", oMulH, oBlkReady, h2);
    end
    clear_q();
    q_data.push_back(y); q_bytes.push_back(5'd16); q_aad.push_back(1'b0);
    send_blocks(1'b0, ok);
    checks++;
    if (!ok || oMulA !== y) begin
      errors++;
      $display("FAIL t5_accclr got %h exp %h ok %0d", oMulA, y, ok);
    end
    pulse_final();
    wait_tag(t, ok);
    checks++;
    if (!ok || t !== ref_ghash(h2)) begin
      errors++;
      $display("FAIL t5_tag got %h exp %h ok %0d", t, ref_ghash(h2), ok);
    end
  endtask

  task automatic test_random();
    logic [127:0] h, t;
    bit ok, okt, fl;
    int nb;
    for (int it = 0; it < 8; it++) begin
      h = rnd128();
      nb = $urandom_range(0, 4);
      fl = $urandom_range(0, 1);
      do_start(h);
      clear_q();
      for (int i = 0; i < nb; i++) begin
        q_data.push_back(rnd128());
        q_bytes.push_back(5'($urandom_range(0, 20)));
        q_aad.push_back(1'($urandom_range(0, 1)));
      end
      send_blocks(fl, ok);
      if (!fl || nb == 0) pulse_final();
      wait_tag(t, okt);
      checks++;
      if (!ok || !okt || t !== ref_ghash(h)) begin
        errors++;
        $display("FAIL rand%0d_tag got %h exp %h nb %0d ok %0d/%0d", it, t, ref_ghash(h), nb, ok, okt);
      end
    end
  endtask

`ifdef GHASH_ORDER_CHK_EN
  task automatic test_order();
    bit ok;
    do_start(rnd128());
    clear_q();
    q_data.push_back(rnd128()); q_bytes.push_back(5'd16); q_aad.push_back(1'b0);
    send_blocks(1'b0, ok);
    checks++;
    if (!ok || oErr !== 1'b0) begin
      errors++;
      $display("FAIL t6_c got %b exp 0", oErr);
    end
    clear_q();
    q_data.push_back(rnd128()); q_bytes.push_back(5'd16); q_aad.push_back(1'b1);
    send_blocks(1'b0, ok);
    checks++;
    if (!ok || oErr !== 1'b1) begin
      errors++;
      $display("FAIL t6_err got %b exp 1", oErr);
    end
    do_start(rnd128());
    checks++;
    if (oErr !== 1'b0) begin
      errors++;
      $display("FAIL t6_clr got %b exp 0", oErr);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    iStart = 1'b0;
    iHashkey = '0;
    iBlkValid = 1'b0;
    iBlkData = '0;
    iBlkIsAad = 1'b0;
    iBlkBytes = '0;
    iFinal = 1'b0;
    test_reset();
    test_single_c();
    test_partial_aad();
    test_back_to_back();
    test_empty();
    test_reset_mid();
    test_abort();
    test_random();
`ifdef GHASH_ORDER_CHK_EN
    test_order();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
